mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one synchronous single-port memory between the video/audio read requesters (spcon, bg0, bg1, ov, au) and the SPI-flash write requester (fl). Each requester uses the existing valid/ready handshake: it presents an address (and data for fl) with valid, and receives a one-cycle ready pulse. Arbitration is round-robin at one access per grant. The block sits between the port controller's memory ports and the shared memory macro.

Parameters:
DATA_BITS, 16, memory word width
ADDR_BITS, 16, memory address width
MEM_LATENCY, 1, cycles from mem_rd high until mem_rdata is valid; legal range 1..4

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
rd_valid  in  5  read request per channel: 0 spcon, 1 bg0, 2 bg1, 3 ov, 4 au
rd_addr  in  5*ADDR_BITS  packed read addresses; channel n at [n*ADDR_BITS +: ADDR_BITS]
rd_ready  out  5  one-cycle pulse per channel; rd_data valid that cycle
rd_data  out  DATA_BITS  shared read-return bus
fl_wvalid  in  1  flash write request (channel 5)
fl_addr  in  ADDR_BITS  write address
fl_wdata  in  DATA_BITS  write data
fl_wready  out  1  one-cycle pulse when the write has been performed
mem_addr  out  ADDR_BITS  memory address
mem_wdata  out  DATA_BITS  memory write data
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_rdata  in  DATA_BITS  memory read data
grant  out  3  index of the channel being serviced; 7 when idle
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: applies whenever RST=1 at a CLK edge, including mid-transaction. Any in-flight access is abandoned with no ready pulse. Register state after reset:
  - state=IDLE; rr_ptr=5, so channel 0 has first priority.
  - All outputs 0, except grant=7.
- Clocking: all outputs are registered. No combinational path from an input to an output.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Request vector is {fl_wvalid, rd_valid[4:0]}.
  - If any request is set, the winner is the first set bit searching upward from rr_ptr+1, modulo 6.
  - On the next edge: latch the winner into grant and rr_ptr, and load mem_addr (plus mem_wdata for a write) from the winner's inputs. Go to ISSUE.
  - With no request, remain in IDLE.
- ISSUE (exactly 1 cycle): mem_rd=1 for a read, or mem_wr=1 for a write.
  - Read: go to WAIT.
  - Write: go to RESP.
- WAIT (exactly MEM_LATENCY cycles): strobes are 0; a counter counts down. In the last WAIT cycle, mem_rdata is captured into rd_data. Then go to RESP.
- RESP (1 cycle): rd_ready[grant]=1 (read) or fl_wready=1 (write). Then go to IDLE.
  - rd_data holds its value until the next read capture; it is not cleared.
- Timing for a request first sampled in IDLE at cycle T:
  - ISSUE at T+1.
  - Read ready at T+2+MEM_LATENCY.
  - Write ready at T+2.
  - Minimum spacing between consecutive grants is 3+MEM_LATENCY cycles for reads and 3 cycles for writes.
- Requester rules:
  - Hold valid, address and data stable until ready.
  - Address/data are sampled only at the IDLE→ISSUE edge; later changes are ignored.
  - If valid drops before ready, the transaction still completes and ready still pulses.
  - Valid still high in the cycle after ready counts as a new request.
- Fairness: a channel that requests continuously is serviced at least once every 6 grants.
- Simultaneous requests on all 6 channels: service order is rr_ptr+1, rr_ptr+2, and so on.
- mem_addr and mem_wdata hold their last values outside ISSUE.

Optional Feature:
Macro MEM_ARB_VIDEO_PRIORITY_EN.
- Defined: two priority classes.
  - Video channels 0..3 form the high class, with their own round-robin pointer.
  - Channels 4..5 are granted only when no video request is present in IDLE, with a separate round-robin pointer.
  - Both pointers reset so that the lowest index in each class wins first.
- Undefined: single 6-way round-robin as described in Behaviour.
- Handshake, timing and reset are identical in both builds.

Test Plan:
- Single read, MEM_LATENCY=1: rd_valid[1]=1, rd_addr ch1=0x1234, memory returns 0xBEEF → mem_rd at T+1 with mem_addr=0x1234; rd_ready[1] pulse at T+3 with rd_data=0xBEEF; grant=1 during T+1..T+3, then 7.
- Write: fl_wvalid=1, fl_addr=0x0400, fl_wdata=0xA55A → mem_wr=1 at T+1 with mem_addr=0x0400 and mem_wdata=0xA55A; fl_wready pulse at T+2; no mem_rd.
- Round-robin: all 6 valid held high after reset (feature undefined) → grant order 0,1,2,3,4,5,0,1; each ready is 1 cycle; gap between grants is 4 cycles for reads and 3 for writes.
- Latency: MEM_LATENCY=3, read on ch4 (au) → WAIT lasts 3 cycles; rd_ready[4] at T+5 with data captured from the third WAIT cycle.
- Reset mid-WAIT: assert RST for 1 cycle during WAIT of a ch2 read → no rd_ready[2]; the next cycle is IDLE with grant=7 and outputs 0; a re-request on ch2 completes normally.
- MEM_ARB_VIDEO_PRIORITY_EN defined: ch5 and ch0 request continuously → ch5 is never granted while ch0 is valid; when ch0 drops, ch5 is granted at the next IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory among five read
// channels and the flash write channel. Optional macro: MEM_ARB_VIDEO_PRIORITY_EN.
module mem_port_arbiter #(
    parameter int DATA_BITS   = 16,
    parameter int ADDR_BITS   = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [4:0]               rd_valid,
    input  logic [5*ADDR_BITS-1:0]   rd_addr,
    output logic [4:0]               rd_ready,
    output logic [DATA_BITS-1:0]     rd_data,
    input  logic                     fl_wvalid,
    input  logic [ADDR_BITS-1:0]     fl_addr,
    input  logic [DATA_BITS-1:0]     fl_wdata,
    output logic                     fl_wready,
    output logic [ADDR_BITS-1:0]     mem_addr,
    output logic [DATA_BITS-1:0]     mem_wdata,
    output logic                     mem_rd,
    output logic                     mem_wr,
    input  logic [DATA_BITS-1:0]     mem_rdata,
    output logic [2:0]               grant,
    output logic                     busy
);
    localparam int NCH = 6;
    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t               r_state, w_state_next;
    logic [2:0]           r_grant, w_grant_next;
    logic [4:0]           r_rd_ready, w_rd_ready_next;
    logic                 r_fl_wready, w_fl_wready_next;
    logic [DATA_BITS-1:0] r_rd_data, w_rd_data_next;
    logic [ADDR_BITS-1:0] r_mem_addr, w_mem_addr_next;
    logic [DATA_BITS-1:0] r_mem_wdata, w_mem_wdata_next;
    logic                 r_mem_rd, w_mem_rd_next;
    logic                 r_mem_wr, w_mem_wr_next;
    logic                 r_busy, w_busy_next;
    logic [2:0]           r_cnt, w_cnt_next;

    logic [5:0]           w_req;
    logic [ADDR_BITS-1:0] w_addr_ch [NCH];
    logic                 w_found;
    logic [2:0]           w_winner;
    logic                 w_take;

    assign w_req  = {fl_wvalid, rd_valid};
    assign w_take = (r_state == S_IDLE) && w_found;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_addr
        if (gi < 5) begin : g_rd
            assign w_addr_ch[gi] = rd_addr[gi*ADDR_BITS +: ADDR_BITS];
        end else begin : g_fl
            assign w_addr_ch[gi] = fl_addr;
        end
    end

`ifdef MEM_ARB_VIDEO_PRIORITY_EN
    // Video class (0..3) always beats the aux class (4..5); each class rotates on its own.
    logic [1:0] r_rr_vid;
    logic       r_rr_aux;
    logic [3:0] w_vreq;
    logic [1:0] w_vcand [4];

    assign w_vreq = w_req[3:0];

    for (genvar gi = 0; gi < 4; gi++) begin : g_vcand
        assign w_vcand[gi] = r_rr_vid + 2'(gi + 1);
    end

    always_comb begin
        w_found  = 1'b0;
        w_winner = 3'd0;
        if (w_req[5:4] != 2'b00) begin
            w_found = 1'b1;
            if (r_rr_aux) w_winner = w_req[4] ? 3'd4 : 3'd5;
            else          w_winner = w_req[5] ? 3'd5 : 3'd4;
        end
        for (int k = 3; k >= 0; k--) begin
            if (w_vreq[w_vcand[k]]) begin
                w_found  = 1'b1;
                w_winner = {1'b0, w_vcand[k]};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rr_vid <= 2'd3;
            r_rr_aux <= 1'b1;
        end else if (w_take) begin
            if (w_winner[2]) r_rr_aux <= w_winner[0];
            else             r_rr_vid <= w_winner[1:0];
        end
    end
`else
    logic [2:0] r_rr_ptr;
    logic [2:0] w_cand [NCH];

    // Candidate gi is the channel gi+1 places after the last winner, modulo 6.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
        logic [3:0] w_sum;
        assign w_sum       = {1'b0, r_rr_ptr} + 4'(gi + 1);
        assign w_cand[gi]  = (w_sum >= 4'd6) ? 3'(w_sum - 4'd6) : w_sum[2:0];
    end

    always_comb begin
        w_found  = 1'b0;
        w_winner = 3'd0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_req[w_cand[k]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[k];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)         r_rr_ptr <= 3'd5;
        else if (w_take) r_rr_ptr <= w_winner;
    end
`endif

    always_comb begin
        w_state_next     = r_state;
        w_grant_next     = r_grant;
        w_rd_ready_next  = 5'd0;
        w_fl_wready_next = 1'b0;
        w_rd_data_next   = r_rd_data;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_mem_rd_next    = 1'b0;
        w_mem_wr_next    = 1'b0;
        w_cnt_next       = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next    = S_ISSUE;
                    w_grant_next    = w_winner;
                    w_mem_addr_next = w_addr_ch[w_winner];
                    if (w_winner == 3'd5) begin
                        w_mem_wdata_next = fl_wdata;
                        w_mem_wr_next    = 1'b1;
                    end else begin
                        w_mem_rd_next    = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (r_grant == 3'd5) begin
                    w_state_next     = S_RESP;
                    w_fl_wready_next = 1'b1;
                end else begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = LAT;
                end
            end
            S_WAIT: begin
                // Data is sampled on the edge that closes the last WAIT cycle.
                if (r_cnt == 3'd1) begin
                    w_state_next    = S_RESP;
                    w_rd_data_next  = mem_rdata;
                    w_rd_ready_next = 5'd1 << r_grant;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
                w_grant_next = 3'd7;
            end
            default: begin
                w_state_next = S_IDLE;
                w_grant_next = 3'd7;
            end
        endcase
        w_busy_next = (w_state_next != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_grant     <= 3'd7;
            r_rd_ready  <= 5'd0;
            r_fl_wready <= 1'b0;
            r_rd_data   <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= 3'd0;
        end else begin
            r_state     <= w_state_next;
            r_grant     <= w_grant_next;
            r_rd_ready  <= w_rd_ready_next;
            r_fl_wready <= w_fl_wready_next;
            r_rd_data   <= w_rd_data_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_mem_rd    <= w_mem_rd_next;
            r_mem_wr    <= w_mem_wr_next;
            r_busy      <= w_busy_next;
            r_cnt       <= w_cnt_next;
        end
    end

    assign rd_ready  = r_rd_ready;
    assign rd_data   = r_rd_data;
    assign fl_wready = r_fl_wready;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign grant     = r_grant;
    assign busy      = r_busy;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table on a MEM_LATENCY=1
// instance, plus hand sequences for round-robin, latency 3 and reset mid-WAIT.
module tb_mem_port_arbiter;
    localparam logic [15:0] JUNK = 16'hDEAD;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  rd_valid, rd_valid3;
    logic [79:0] rd_addr;
    logic        fl_wvalid, fl_wvalid3;
    logic [15:0] fl_addr, fl_wdata;

    logic [4:0]  rd_ready, rd_ready3;
    logic [15:0] rd_data, rd_data3;
    logic        fl_wready, fl_wready3;
    logic [15:0] mem_addr, mem_addr3, mem_wdata, mem_wdata3;
    logic        mem_rd, mem_rd3, mem_wr, mem_wr3;
    logic [15:0] mem_rdata, mem_rdata3;
    logic [2:0]  grant, grant3;
    logic        busy, busy3;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.DATA_BITS(16), .ADDR_BITS(16), .MEM_LATENCY(1)) dut (
        .CLK(CLK), .RST(RST), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .rd_data(rd_data), .fl_wvalid(fl_wvalid),
        .fl_addr(fl_addr), .fl_wdata(fl_wdata), .fl_wready(fl_wready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
    );

    mem_port_arbiter #(.DATA_BITS(16), .ADDR_BITS(16), .MEM_LATENCY(3)) dut3 (
        .CLK(CLK), .RST(RST), .rd_valid(rd_valid3), .rd_addr(rd_addr),
        .rd_ready(rd_ready3), .rd_data(rd_data3), .fl_wvalid(fl_wvalid3),
        .fl_addr(fl_addr), .fl_wdata(fl_wdata), .fl_wready(fl_wready3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rd(mem_rd3),
        .mem_wr(mem_wr3), .mem_rdata(mem_rdata3), .grant(grant3), .busy(busy3)
    );

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'hC3C3);
    endfunction

    // Memory models: data is valid exactly MEM_LATENCY cycles after mem_rd, junk otherwise.
    logic [15:0] pipe1;
    logic [15:0] pipe3 [3];
    always @(posedge CLK) begin
        pipe1    <= mem_rd ? mem_fn(mem_addr) : JUNK;
        pipe3[0] <= mem_rd3 ? mem_fn(mem_addr3) : JUNK;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mem_rdata  = pipe1;
    assign mem_rdata3 = pipe3[2];

    typedef struct packed {
        logic [4:0]  v;
        logic        f;
        logic [2:0]  g;
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [15:0] wd;
        logic [4:0]  rdy;
        logic        fw;
        logic        b;
        logic [15:0] d;
    } vec_t;

    vec_t tbl [16];

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic do_reset();
        rd_valid   = 5'd0;
        rd_valid3  = 5'd0;
        fl_wvalid  = 1'b0;
        fl_wvalid3 = 1'b0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Ticks until the L=1 instance is in ISSUE; a missing grant counts as a failure.
    task automatic wait_issue(input string name, output logic [2:0] g, output bit ok);
        ok = 1'b0;
        g  = 3'd7;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (mem_rd || mem_wr) begin
                ok = 1'b1;
                g  = grant;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no grant within 8 cycles, want a grant", name);
        end
    endtask

    initial begin
        logic [2:0] g;
        bit         ok;
        int         last_cyc;
        bit         last_wr;
        logic [2:0] exp_order [8];

        rd_addr  = {16'h4400, 16'h00F0, 16'h2200, 16'h1234, 16'h0100};
        fl_addr  = 16'h0400;
        fl_wdata = 16'hA55A;

        //            v      f     g     rd    wr    addr      wdata     rdy    fw    b     rd_data
        tbl[0]  = '{5'h00, 1'b0, 3'd7, 1'b0, 1'b0, 16'h0000, 16'h0000, 5'h00, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{5'h02, 1'b0, 3'd1, 1'b1, 1'b0, 16'h1234, 16'h0000, 5'h00, 1'b0, 1'b1, 16'h0000};
        tbl[2]  = '{5'h02, 1'b0, 3'd1, 1'b0, 1'b0, 16'h1234, 16'h0000, 5'h00, 1'b0, 1'b1, 16'h0000};
        tbl[3]  = '{5'h02, 1'b0, 3'd1, 1'b0, 1'b0, 16'h1234, 16'h0000, 5'h02, 1'b0, 1'b1, 16'hBEEF};
        tbl[4]  = '{5'h00, 1'b0, 3'd7, 1'b0, 1'b0, 16'h1234, 16'h0000, 5'h00, 1'b0, 1'b0, 16'hBEEF};
        tbl[5]  = '{5'h00, 1'b1, 3'd5, 1'b0, 1'b1, 16'h0400, 16'hA55A, 5'h00, 1'b0, 1'b1, 16'hBEEF};
        tbl[6]  = '{5'h00, 1'b1, 3'd5, 1'b0, 1'b0, 16'h0400, 16'hA55A, 5'h00, 1'b1, 1'b1, 16'hBEEF};
        tbl[7]  = '{5'h00, 1'b0, 3'd7, 1'b0, 1'b0, 16'h0400, 16'hA55A, 5'h00, 1'b0, 1'b0, 16'hBEEF};
        tbl[8]  = '{5'h08, 1'b0, 3'd3, 1'b1, 1'b0, 16'h00F0, 16'hA55A, 5'h00, 1'b0, 1'b1, 16'hBEEF};
        tbl[9]  = '{5'h08, 1'b0, 3'd3, 1'b0, 1'b0, 16'h00F0, 16'hA55A, 5'h00, 1'b0, 1'b1, 16'hBEEF};
        tbl[10] = '{5'h08, 1'b0, 3'd3, 1'b0, 1'b0, 16'h00F0, 16'hA55A, 5'h08, 1'b0, 1'b1, 16'hC333};
        tbl[11] = '{5'h00, 1'b0, 3'd7, 1'b0, 1'b0, 16'h00F0, 16'hA55A, 5'h00, 1'b0, 1'b0, 16'hC333};
        // ch0 drops valid right after being granted; the read must still complete.
        tbl[12] = '{5'h01, 1'b0, 3'd0, 1'b1, 1'b0, 16'h0100, 16'hA55A, 5'h00, 1'b0, 1'b1, 16'hC333};
        tbl[13] = '{5'h00, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0100, 16'hA55A, 5'h00, 1'b0, 1'b1, 16'hC333};
        tbl[14] = '{5'h00, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0100, 16'hA55A, 5'h01, 1'b0, 1'b1, 16'hC2C3};
        tbl[15] = '{5'h00, 1'b0, 3'd7, 1'b0, 1'b0, 16'h0100, 16'hA55A, 5'h00, 1'b0, 1'b0, 16'hC2C3};

`ifdef MEM_ARB_VIDEO_PRIORITY_EN
        exp_order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
`else
        exp_order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
`endif

        do_reset();

        for (int i = 0; i < 16; i++) begin
            rd_valid  = tbl[i].v;
            fl_wvalid = tbl[i].f;
            tick();
            chk($sformatf("row%0d grant", i),     16'(grant),     16'(tbl[i].g));
            chk($sformatf("row%0d mem_rd", i),    16'(mem_rd),    16'(tbl[i].rd));
            chk($sformatf("row%0d mem_wr", i),    16'(mem_wr),    16'(tbl[i].wr));
            chk($sformatf("row%0d mem_addr", i),  mem_addr,       tbl[i].a);
            chk($sformatf("row%0d mem_wdata", i), mem_wdata,      tbl[i].wd);
            chk($sformatf("row%0d rd_ready", i),  16'(rd_ready),  16'(tbl[i].rdy));
            chk($sformatf("row%0d fl_wready", i), 16'(fl_wready), 16'(tbl[i].fw));
            chk($sformatf("row%0d busy", i),      16'(busy),      16'(tbl[i].b));
            chk($sformatf("row%0d rd_data", i),   rd_data,        tbl[i].d);
        end

        // All six requesters held high: grant order, one-cycle readies and grant spacing.
        do_reset();
        rd_valid  = 5'h1F;
        fl_wvalid = 1'b1;
        last_cyc  = 0;
        last_wr   = 1'b0;
        for (int n = 0; n < 8; n++) begin
            wait_issue($sformatf("rr%0d issue", n), g, ok);
            if (!ok) break;
            chk($sformatf("rr%0d grant", n), 16'(g), 16'(exp_order[n]));
            if (n > 0) chk($sformatf("rr%0d gap", n), 16'(cyc - last_cyc), last_wr ? 16'd3 : 16'd4);
            last_cyc = cyc;
            last_wr  = mem_wr;
            if (mem_wr) begin
                tick();
                chk($sformatf("rr%0d fl_wready", n), 16'(fl_wready), 16'd1);
                tick();
                chk($sformatf("rr%0d fl_wready off", n), 16'(fl_wready), 16'd0);
                chk($sformatf("rr%0d idle grant", n), 16'(grant), 16'd7);
            end else begin
                tick();
                chk($sformatf("rr%0d rd_ready wait", n), 16'(rd_ready), 16'd0);
                tick();
                chk($sformatf("rr%0d rd_ready", n), 16'(rd_ready), 16'(5'd1 << g));
                tick();
                chk($sformatf("rr%0d rd_ready off", n), 16'(rd_ready), 16'd0);
                chk($sformatf("rr%0d idle grant", n), 16'(grant), 16'd7);
            end
        end

        // MEM_LATENCY=3 read on ch4: three WAIT cycles, ready and data at T+5.
        do_reset();
        rd_valid3 = 5'h10;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("lat3 c%0d mem_rd", k), 16'(mem_rd3), (k == 1) ? 16'd1 : 16'd0);
            chk($sformatf("lat3 c%0d rd_ready", k), 16'(rd_ready3), (k == 5) ? 16'h10 : 16'd0);
            chk($sformatf("lat3 c%0d busy", k), 16'(busy3), (k <= 5) ? 16'd1 : 16'd0);
            if (k == 5) begin
                chk("lat3 rd_data", rd_data3, 16'h87C3);
                rd_valid3 = 5'd0;
            end
            if (k == 6) chk("lat3 idle grant", 16'(grant3), 16'd7);
        end

        // Reset during WAIT of a ch2 read abandons it; a re-request then completes.
        do_reset();
        rd_valid = 5'h04;
        tick();
        chk("rst issue grant", 16'(grant), 16'd2);
        chk("rst issue mem_rd", 16'(mem_rd), 16'd1);
        tick();
        chk("rst wait busy", 16'(busy), 16'd1);
        RST = 1'b1;
        rd_valid = 5'd0;
        tick();
        RST = 1'b0;
        chk("rst after grant", 16'(grant), 16'd7);
        chk("rst after busy", 16'(busy), 16'd0);
        chk("rst after mem_addr", mem_addr, 16'h0000);
        chk("rst after rd_ready", 16'(rd_ready), 16'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rst no ready c%0d", k), 16'(rd_ready), 16'd0);
        end
        rd_valid = 5'h04;
        tick();
        chk("rerq grant", 16'(grant), 16'd2);
        chk("rerq mem_addr", mem_addr, 16'h2200);
        tick();
        tick();
        chk("rerq rd_ready", 16'(rd_ready), 16'h04);
        chk("rerq rd_data", rd_data, 16'hE1C3);
        rd_valid = 5'd0;
        tick();
        chk("rerq idle grant", 16'(grant), 16'd7);

`ifdef MEM_ARB_VIDEO_PRIORITY_EN
        // ch0 and ch5 both request: ch5 waits until ch0 drops.
        do_reset();
        rd_valid  = 5'h01;
        fl_wvalid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            wait_issue($sformatf("prio%0d issue", n), g, ok);
            if (!ok) break;
            chk($sformatf("prio%0d grant", n), 16'(g), 16'd0);
            tick();
            tick();
            if (n == 2) rd_valid = 5'd0;
            tick();
        end
        wait_issue("prio fl issue", g, ok);
        if (ok) chk("prio fl grant", 16'(g), 16'd5);
        fl_wvalid = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end
endmodule
